// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: assembles a 32-bit big-endian word from four byte reads on an 8-bit external bus.
// Define FETCH_HIT_BUF_EN to keep the last fetched word and serve repeat fetches of it with no external access.
module inst_fetch_bridge #(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned MEM_ADDR_W  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rom_ce_i,
    input  logic [31:0]           rom_addr_i,
    output logic [31:0]           rom_data_o,
    output logic                  stallreq_o,
    output logic [MEM_ADDR_W-1:0] mem_addr_o,
    output logic                  mem_oe_n_o,
    input  logic [7:0]            mem_data_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DONE
    } state_e;

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES);

    state_e                state_q, state_d;
    logic [MEM_ADDR_W-3:0] tag_q, tag_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [2:0]            wait_cnt_q, wait_cnt_d;
    logic [31:0]           word_q, word_d;

    logic [MEM_ADDR_W-3:0] req_tag;
    logic                  tag_match;
    logic                  hit;
    logic                  unused_addr;

    assign req_tag     = rom_addr_i[MEM_ADDR_W-1:2];
    assign tag_match   = (req_tag == tag_q);
    assign unused_addr = ^{rom_addr_i[31:MEM_ADDR_W], rom_addr_i[1:0]};

`ifdef FETCH_HIT_BUF_EN
    logic valid_q, valid_d;

    assign hit = rom_ce_i & valid_q & tag_match;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        tag_d      = tag_q;
        byte_cnt_d = byte_cnt_q;
        wait_cnt_d = wait_cnt_q;
        word_d     = word_q;
`ifdef FETCH_HIT_BUF_EN
        valid_d    = valid_q;
`endif
        mem_addr_o = '0;
        mem_oe_n_o = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (rom_ce_i && !hit) begin
                    tag_d      = req_tag;
                    byte_cnt_d = '0;
                    wait_cnt_d = '0;
                    state_d    = ST_FETCH;
`ifdef FETCH_HIT_BUF_EN
                    // Tag is being replaced, so the held word no longer matches it.
                    valid_d    = 1'b0;
`endif
                end
            end
            ST_FETCH: begin
                mem_addr_o = {tag_q, byte_cnt_q};
                mem_oe_n_o = 1'b0;
                if (!rom_ce_i || !tag_match) begin
                    byte_cnt_d = '0;
                    wait_cnt_d = '0;
                    state_d    = ST_IDLE;
`ifdef FETCH_HIT_BUF_EN
                    valid_d    = 1'b0;
`endif
                end else if (wait_cnt_q == WAIT_LAST) begin
                    case (byte_cnt_q)
                        2'd0:    word_d[31:24] = mem_data_i;
                        2'd1:    word_d[23:16] = mem_data_i;
                        2'd2:    word_d[15:8]  = mem_data_i;
                        default: word_d[7:0]   = mem_data_i;
                    endcase
                    wait_cnt_d = '0;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
`ifdef FETCH_HIT_BUF_EN
                valid_d = 1'b1;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stall is gated by rst so it drops in the same cycle reset is asserted.
    always_comb begin
        rom_data_o = '0;
        stallreq_o = 1'b0;
        if (hit || state_q == ST_DONE) begin
            rom_data_o = word_q;
        end
        if (rst && rom_ce_i && !hit && !(state_q == ST_DONE && tag_match)) begin
            stallreq_o = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            tag_q      <= '0;
            byte_cnt_q <= '0;
            wait_cnt_q <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            byte_cnt_q <= byte_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            word_q     <= word_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed bench for inst_fetch_bridge: one instance with WAIT_STATES=1, one with WAIT_STATES=0.
// Hit-buffer expectations follow FETCH_HIT_BUF_EN as defined for the build.
module tb_inst_fetch_bridge;

    localparam int unsigned AW  = 20;
    localparam int unsigned WS1 = 1;
    localparam int unsigned WS0 = 0;

    logic          clk;
    logic          rst;

    logic          ce1, ce0;
    logic [31:0]   addr1, addr0;
    logic [31:0]   data1, data0;
    logic          stall1, stall0;
    logic [AW-1:0] maddr1, maddr0;
    logic          oe_n1, oe_n0;
    logic [7:0]    mdata1, mdata0;

    logic [7:0]    mem [0:31];

    int unsigned   n_checks;
    int unsigned   n_fail;

    inst_fetch_bridge #(.WAIT_STATES(WS1), .MEM_ADDR_W(AW)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .rom_ce_i   (ce1),
        .rom_addr_i (addr1),
        .rom_data_o (data1),
        .stallreq_o (stall1),
        .mem_addr_o (maddr1),
        .mem_oe_n_o (oe_n1),
        .mem_data_i (mdata1)
    );

    inst_fetch_bridge #(.WAIT_STATES(WS0), .MEM_ADDR_W(AW)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .rom_ce_i   (ce0),
        .rom_addr_i (addr0),
        .rom_data_o (data0),
        .stallreq_o (stall0),
        .mem_addr_o (maddr0),
        .mem_oe_n_o (oe_n0),
        .mem_data_i (mdata0)
    );

    // Asynchronous external memory; floats high when not enabled.
    assign mdata1 = oe_n1 ? 8'hFF : mem[maddr1[4:0]];
    assign mdata0 = oe_n0 ? 8'hFF : mem[maddr0[4:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full fetch on dut1 starting in an IDLE cycle; word appears 4*(WS1+1)+1 cycles later.
    task automatic fetch1(input logic [31:0] a, input logic [31:0] exp, input string tag);
        int unsigned lat;
        logic [31:0] exp_addr;
        lat   = 4 * (WS1 + 1) + 1;
        ce1   = 1'b1;
        addr1 = a;
        for (int unsigned c = 0; c <= lat; c++) begin
            #1;
            if (c < lat) begin
                check($sformatf("%s_stall_c%0d", tag, c), {31'd0, stall1}, 32'd1);
            end else begin
                check($sformatf("%s_stall_done", tag), {31'd0, stall1}, 32'd0);
                check($sformatf("%s_data", tag), data1, exp);
            end
            if (c == 0) begin
                check($sformatf("%s_oe_idle", tag), {31'd0, oe_n1}, 32'd1);
            end else if (c < lat) begin
                exp_addr = (a & 32'h000F_FFFC) | ((c - 1) / (WS1 + 1));
                check($sformatf("%s_maddr_c%0d", tag, c), {12'd0, maddr1}, exp_addr);
                check($sformatf("%s_oe_c%0d", tag, c), {31'd0, oe_n1}, 32'd0);
            end
            tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mem      = '{default: 8'h00};
        mem[0]  = 8'h34; mem[1]  = 8'h01; mem[2]  = 8'h11; mem[3]  = 8'h00;
        mem[4]  = 8'h12; mem[5]  = 8'h34; mem[6]  = 8'h56; mem[7]  = 8'h78;
        mem[8]  = 8'hA5; mem[9]  = 8'h5A; mem[10] = 8'hC3; mem[11] = 8'h3C;
        mem[16] = 8'hDE; mem[17] = 8'hAD; mem[18] = 8'hBE; mem[19] = 8'hEF;

        rst   = 1'b0;
        ce1   = 1'b1;
        addr1 = 32'h0;
        ce0   = 1'b0;
        addr0 = 32'h0;
        tick();
        tick();
        #1;
        check("rst_stall", {31'd0, stall1}, 32'd0);
        check("rst_data", data1, 32'd0);
        check("rst_oe", {31'd0, oe_n1}, 32'd1);
        check("rst_maddr", {12'd0, maddr1}, 32'd0);
        rst = 1'b1;

        // First word, then the same pc held after delivery.
        fetch1(32'h0, 32'h3401_1100, "w0");
`ifdef FETCH_HIT_BUF_EN
        for (int unsigned c = 0; c < 3; c++) begin
            #1;
            check($sformatf("hit_stall_c%0d", c), {31'd0, stall1}, 32'd0);
            check($sformatf("hit_data_c%0d", c), data1, 32'h3401_1100);
            check($sformatf("hit_oe_c%0d", c), {31'd0, oe_n1}, 32'd1);
            tick();
        end
`else
        fetch1(32'h0, 32'h3401_1100, "refetch");
`endif

        // Core advances on each delivery; upper address bits and low two bits are don't-care.
        fetch1(32'h0000_0004, 32'h1234_5678, "w4");
        fetch1(32'hFFF0_000B, 32'hA55A_C33C, "w8");

        // Address change mid-fetch aborts and restarts from IDLE.
        ce1   = 1'b1;
        addr1 = 32'h0;
        tick(); tick(); tick();
        addr1 = 32'h10;
        #1;
        check("abort_addr_stall", {31'd0, stall1}, 32'd1);
        tick();
        #1;
        check("abort_addr_oe", {31'd0, oe_n1}, 32'd1);
        check("abort_addr_maddr", {12'd0, maddr1}, 32'd0);
        fetch1(32'h10, 32'hDEAD_BEEF, "w10");

        // Request withdrawn mid-fetch.
        ce1   = 1'b1;
        addr1 = 32'h4;
        tick(); tick();
        ce1 = 1'b0;
        #1;
        check("abort_ce_stall", {31'd0, stall1}, 32'd0);
        check("abort_ce_data", data1, 32'd0);
        tick();
        #1;
        check("abort_ce_oe", {31'd0, oe_n1}, 32'd1);

        // Asynchronous reset in the middle of a fetch.
        ce1   = 1'b1;
        addr1 = 32'h8;
        tick(); tick(); tick(); tick(); tick();
        #1;
        check("midrst_pre_oe", {31'd0, oe_n1}, 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_oe", {31'd0, oe_n1}, 32'd1);
        check("midrst_maddr", {12'd0, maddr1}, 32'd0);
        check("midrst_stall", {31'd0, stall1}, 32'd0);
        check("midrst_data", data1, 32'd0);
        tick();
        rst = 1'b1;
        fetch1(32'h8, 32'hA55A_C33C, "post_rst");

        // Zero-wait instance: idle outputs, then one fetch of word 0.
        ce1 = 1'b0;
        for (int unsigned c = 0; c < 3; c++) begin
            #1;
            check($sformatf("ws0_idle_stall_c%0d", c), {31'd0, stall0}, 32'd0);
            check($sformatf("ws0_idle_data_c%0d", c), data0, 32'd0);
            check($sformatf("ws0_idle_oe_c%0d", c), {31'd0, oe_n0}, 32'd1);
            tick();
        end
        ce0   = 1'b1;
        addr0 = 32'h0;
        for (int unsigned c = 0; c <= 5; c++) begin
            #1;
            if (c < 5) begin
                check($sformatf("ws0_stall_c%0d", c), {31'd0, stall0}, 32'd1);
            end else begin
                check("ws0_stall_done", {31'd0, stall0}, 32'd0);
                check("ws0_data", data0, 32'h3401_1100);
            end
            if (c >= 1 && c <= 4) begin
                check($sformatf("ws0_maddr_c%0d", c), {12'd0, maddr0}, c - 1);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
